// File: rtl/lcd_hd44780_responder.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_responder
//
// Display end of an HD44780-style 8-bit parallel LCD bus. It decodes
// instructions and data from an initiator, keeps the 80-byte DDRAM, the
// address counter and the display state, and models the busy time.
// DDRAM contents are exposed through a registered read port and a
// write-event stream so the text can be mirrored onto other displays.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   lcd_rs/lcd_rw/lcd_e     bus controls (lcd_e is asynchronous to clk)
//   lcd_data                bus data from the initiator
//   lcd_data_out/_oe        read data and its drive enable
//   rd_addr/rd_data         DDRAM read port, 1-cycle latency
//   wr_valid/addr/char      one pulse per DDRAM character write
//   busy, ac                busy flag and address counter
//   display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line,
//   shift_ofs               display state registers
//   overrun                 sticky: an access arrived while busy
//   addr_err                pulse: set-DDRAM-address with an invalid address
//
// DDRAM mapping: in two-line mode 0x00-0x27 -> 0..39 and 0x40-0x67 -> 40..79;
// in one-line mode 0x00-0x4F -> 0..79. Anything else is unmapped and reads
// back as a space. SYNC_STAGES must be at least 2 and each busy time at
// least 2.
// ---------------------------------------------------------------------------
module lcd_hd44780_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BUSY_SHORT  = 32'd2000,
  parameter logic [31:0] BUSY_LONG   = 32'd82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_char,
  output logic       busy,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       two_line,
  output logic [5:0] shift_ofs,
  output logic       overrun,
  output logic       addr_err
);

  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_IDLE = 2'd1,
    S_EXEC = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  // True when address a exists in DDRAM for the given line mode.
  function automatic logic addr_ok(input logic [6:0] a, input logic tl);
    logic ok;
    if (tl) begin
      ok = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    end else begin
      ok = (a <= 7'h4F);
    end
    return ok;
  endfunction

  // Physical storage index of a mapped address (second line starts at 40).
  function automatic logic [6:0] phys_idx(input logic [6:0] a, input logic tl);
    logic [6:0] idx;
    if (tl && a[6]) begin
      idx = a - 7'd24;
    end else begin
      idx = a;
    end
    return idx;
  endfunction

  // Address counter step with the line-wrap rules of the current mode.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic tl,
                                         input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (tl && (a == 7'h27))       n = 7'h40;
      else if (tl && (a == 7'h67))  n = 7'h00;
      else if (!tl && (a == 7'h4F)) n = 7'h00;
      else                          n = a + 7'd1;
    end else begin
      if (tl && (a == 7'h00))       n = 7'h67;
      else if (tl && (a == 7'h40))  n = 7'h27;
      else if (!tl && (a == 7'h00)) n = 7'h4F;
      else                          n = a - 7'd1;
    end
    return n;
  endfunction

  // Display shift offset step, modulo 40.
  function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic inc);
    logic [5:0] n;
    if (inc) begin
      n = (o == 6'd39) ? 6'd0 : o + 6'd1;
    end else begin
      n = (o == 6'd0) ? 6'd39 : o - 6'd1;
    end
    return n;
  endfunction

  logic [SYNC_STAGES-1:0] e_sync_r;
  logic                   e_prev_r;
  logic                   e_s, fall_s, rise_s, status_rd_s;

  state_t      state_r, state_s;
  logic [6:0]  clr_idx_r, clr_idx_s;
  logic [31:0] busy_cnt_r, busy_cnt_s;
  logic        cap_rs_r, cap_rs_s, cap_rw_r, cap_rw_s;
  logic [7:0]  cap_data_r, cap_data_s;
  logic        cap_clear_s, cap_home_s;
  logic        cgram_mode_r, cgram_mode_s;

  logic [6:0]  ac_r, ac_s;
  logic        display_on_r, display_on_s, cursor_on_r, cursor_on_s;
  logic        blink_on_r, blink_on_s, entry_inc_r, entry_inc_s;
  logic        entry_shift_r, entry_shift_s, two_line_r, two_line_s;
  logic [5:0]  shift_ofs_r, shift_ofs_s;
  logic        overrun_r, overrun_s, addr_err_r, addr_err_s;
  logic        wr_valid_r, wr_valid_s;
  logic [6:0]  wr_addr_r, wr_addr_s;
  logic [7:0]  wr_char_r, wr_char_s;
  logic        busy_r, busy_s;
  logic [7:0]  data_out_r, data_out_s;
  logic        oe_r, oe_s;
  logic [7:0]  rd_data_r;

  logic [7:0]  mem_r [0:79];
  logic        mem_we_s;
  logic [6:0]  mem_idx_s;
  logic [7:0]  mem_wdata_s;
  logic [7:0]  mem_ac_s;

  assign e_s         = e_sync_r[SYNC_STAGES-1];
  assign fall_s      = e_prev_r & ~e_s;
  assign rise_s      = ~e_prev_r & e_s;
  assign status_rd_s = lcd_rw & ~lcd_rs;
  assign cap_clear_s = ~cap_rs_r & ~cap_rw_r & (cap_data_r == 8'h01);
  assign cap_home_s  = ~cap_rs_r & ~cap_rw_r & (cap_data_r[7:1] == 7'h01);

  // Synchronize the asynchronous enable strobe and keep its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_sync_r <= '0;
      e_prev_r <= 1'b0;
    end else begin
      e_sync_r <= {e_sync_r[SYNC_STAGES-2:0], lcd_e};
      e_prev_r <= e_s;
    end
  end

  // DDRAM character at the address counter, spaces for unmapped addresses.
  always_comb begin
    mem_ac_s = 8'h20;
    if (addr_ok(ac_r, two_line_r)) begin
      mem_ac_s = mem_r[phys_idx(ac_r, two_line_r)];
    end else begin
      mem_ac_s = 8'h20;
    end
  end

  // Next-state and next-register logic for the FSM and display state.
  always_comb begin
    state_s       = state_r;
    clr_idx_s     = clr_idx_r;
    busy_cnt_s    = busy_cnt_r;
    cgram_mode_s  = cgram_mode_r;
    ac_s          = ac_r;
    display_on_s  = display_on_r;
    cursor_on_s   = cursor_on_r;
    blink_on_s    = blink_on_r;
    entry_inc_s   = entry_inc_r;
    entry_shift_s = entry_shift_r;
    two_line_s    = two_line_r;
    shift_ofs_s   = shift_ofs_r;
    wr_valid_s    = 1'b0;
    wr_addr_s     = wr_addr_r;
    wr_char_s     = wr_char_r;
    addr_err_s    = 1'b0;
    mem_we_s      = 1'b0;
    mem_idx_s     = 7'd0;
    mem_wdata_s   = 8'h00;

    cap_rs_s   = fall_s ? lcd_rs   : cap_rs_r;
    cap_rw_s   = fall_s ? lcd_rw   : cap_rw_r;
    cap_data_s = fall_s ? lcd_data : cap_data_r;

    // Any access other than a status read is dropped while not idle.
    overrun_s = overrun_r | (fall_s & (state_r != S_IDLE) & ~status_rd_s);

    // Reads latch their value on the synced rising edge of E.
    data_out_s = (rise_s && lcd_rw) ? (lcd_rs ? mem_ac_s : {busy_r, ac_r})
                                    : data_out_r;
    oe_s       = rise_s ? lcd_rw : (e_s & oe_r);

    case (state_r)
      S_CLR: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = clr_idx_r;
        mem_wdata_s = 8'h20;
        if (clr_idx_r == 7'd79) begin
          clr_idx_s    = 7'd0;
          ac_s         = 7'd0;
          entry_inc_s  = 1'b1;
          shift_ofs_s  = 6'd0;
          cgram_mode_s = 1'b0;
          busy_cnt_s   = BUSY_LONG;
          state_s      = S_BUSY;
        end else begin
          clr_idx_s = clr_idx_r + 7'd1;
          state_s   = S_CLR;
        end
      end

      // The access is decoded as it is captured, so its effect is visible
      // in the first S_EXEC cycle together with busy.
      S_IDLE: begin
        if (fall_s && !status_rd_s) begin
          state_s = S_EXEC;
          if (lcd_rw) begin
            ac_s = ac_step(ac_r, two_line_r, entry_inc_r);
          end else if (lcd_rs) begin
            if (!cgram_mode_r && addr_ok(ac_r, two_line_r)) begin
              mem_we_s    = 1'b1;
              mem_idx_s   = phys_idx(ac_r, two_line_r);
              mem_wdata_s = lcd_data;
              wr_valid_s  = 1'b1;
              wr_addr_s   = ac_r;
              wr_char_s   = lcd_data;
            end else begin
              mem_we_s = 1'b0;
            end
            ac_s = ac_step(ac_r, two_line_r, entry_inc_r);
            if (entry_shift_r) begin
              shift_ofs_s = ofs_step(shift_ofs_r, entry_inc_r);
            end else begin
              shift_ofs_s = shift_ofs_r;
            end
          end else begin
            casez (lcd_data)
              8'b1???????: begin
                cgram_mode_s = 1'b0;
                if (addr_ok(lcd_data[6:0], two_line_r)) begin
                  ac_s = lcd_data[6:0];
                end else begin
                  addr_err_s = 1'b1;
                end
              end
              8'b01??????: cgram_mode_s = 1'b1;
              8'b001?????: two_line_s = lcd_data[3];
              8'b0001????: begin
                if (lcd_data[3]) begin
                  shift_ofs_s = ofs_step(shift_ofs_r, lcd_data[2]);
                end else begin
                  ac_s = ac_step(ac_r, two_line_r, lcd_data[2]);
                end
              end
              8'b00001???: begin
                display_on_s = lcd_data[2];
                cursor_on_s  = lcd_data[1];
                blink_on_s   = lcd_data[0];
              end
              8'b000001??: begin
                entry_inc_s   = lcd_data[1];
                entry_shift_s = lcd_data[0];
              end
              8'b0000001?: begin
                ac_s         = 7'd0;
                shift_ofs_s  = 6'd0;
                cgram_mode_s = 1'b0;
              end
              // Clear display is handled in S_EXEC; 0x00 is a no-op.
              default: ac_s = ac_r;
            endcase
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      // EXEC plus BUSY together last the nominal busy time.
      S_EXEC: begin
        if (cap_clear_s) begin
          clr_idx_s = 7'd0;
          state_s   = S_CLR;
        end else begin
          busy_cnt_s = cap_home_s ? (BUSY_LONG - 32'd2) : (BUSY_SHORT - 32'd2);
          state_s    = S_BUSY;
        end
      end

      S_BUSY: begin
        if (busy_cnt_r == 32'd0) begin
          state_s = S_IDLE;
        end else begin
          busy_cnt_s = busy_cnt_r - 32'd1;
          state_s    = S_BUSY;
        end
      end

      default: state_s = S_CLR;
    endcase

    busy_s = (state_s != S_IDLE);
  end

  // FSM and display-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_CLR;
      clr_idx_r     <= 7'd0;
      busy_cnt_r    <= 32'd0;
      cap_rs_r      <= 1'b0;
      cap_rw_r      <= 1'b0;
      cap_data_r    <= 8'h00;
      cgram_mode_r  <= 1'b0;
      ac_r          <= 7'd0;
      display_on_r  <= 1'b0;
      cursor_on_r   <= 1'b0;
      blink_on_r    <= 1'b0;
      entry_inc_r   <= 1'b1;
      entry_shift_r <= 1'b0;
      two_line_r    <= 1'b0;
      shift_ofs_r   <= 6'd0;
      overrun_r     <= 1'b0;
      addr_err_r    <= 1'b0;
      wr_valid_r    <= 1'b0;
      wr_addr_r     <= 7'd0;
      wr_char_r     <= 8'h00;
      busy_r        <= 1'b0;
      data_out_r    <= 8'h00;
      oe_r          <= 1'b0;
    end else begin
      state_r       <= state_s;
      clr_idx_r     <= clr_idx_s;
      busy_cnt_r    <= busy_cnt_s;
      cap_rs_r      <= cap_rs_s;
      cap_rw_r      <= cap_rw_s;
      cap_data_r    <= cap_data_s;
      cgram_mode_r  <= cgram_mode_s;
      ac_r          <= ac_s;
      display_on_r  <= display_on_s;
      cursor_on_r   <= cursor_on_s;
      blink_on_r    <= blink_on_s;
      entry_inc_r   <= entry_inc_s;
      entry_shift_r <= entry_shift_s;
      two_line_r    <= two_line_s;
      shift_ofs_r   <= shift_ofs_s;
      overrun_r     <= overrun_s;
      addr_err_r    <= addr_err_s;
      wr_valid_r    <= wr_valid_s;
      wr_addr_r     <= wr_addr_s;
      wr_char_r     <= wr_char_s;
      busy_r        <= busy_s;
      data_out_r    <= data_out_s;
      oe_r          <= oe_s;
    end
  end

  // DDRAM storage; the clear fill rewrites it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Registered DDRAM read port for mirroring logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 8'h00;
    end else if (addr_ok(rd_addr, two_line_r)) begin
      rd_data_r <= mem_r[phys_idx(rd_addr, two_line_r)];
    end else begin
      rd_data_r <= 8'h20;
    end
  end

  assign lcd_data_out = data_out_r;
  assign lcd_data_oe  = oe_r;
  assign rd_data      = rd_data_r;
  assign wr_valid     = wr_valid_r;
  assign wr_addr      = wr_addr_r;
  assign wr_char      = wr_char_r;
  assign busy         = busy_r;
  assign ac           = ac_r;
  assign display_on   = display_on_r;
  assign cursor_on    = cursor_on_r;
  assign blink_on     = blink_on_r;
  assign entry_inc    = entry_inc_r;
  assign entry_shift  = entry_shift_r;
  assign two_line     = two_line_r;
  assign shift_ofs    = shift_ofs_r;
  assign overrun      = overrun_r;
  assign addr_err     = addr_err_r;

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable HD44780-compatible character-LCD responder: the display end of the 8-bit parallel LCD bus (rs/rw/e/data) that our LCD driver blocks initiate.
- Decodes instructions, maintains the 80-byte DDRAM, the address counter (AC) and display state, and models busy time.
- Exposes DDRAM through a read port and a write-event stream. Used as the bus-functional target in system sims and to mirror LCD content onto other outputs (VGA/7-seg) on the board.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on lcd_e.
- BUSY_SHORT, 2000, busy cycles for normal instructions and data writes (40 us at 50 MHz).
- BUSY_LONG, 82000, busy cycles for clear display and return home (1.64 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lcd_rs  in  1  register select (0 = instruction, 1 = data).
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_e  in  1  enable strobe, asynchronous to clk.
- lcd_data  in  8  bus data from the initiator.
- lcd_data_out  out  8  read data.
- lcd_data_oe  out  1  read-drive enable.
- rd_addr  in  7  DDRAM read-port address.
- rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency.
- wr_valid  out  1  1-cycle pulse on each DDRAM write.
- wr_addr  out  7  address of that write.
- wr_char  out  8  character of that write.
- busy  out  1  busy flag.
- ac  out  7  address counter.
- display_on, cursor_on, blink_on  out  1 each  display-control bits.
- entry_inc, entry_shift  out  1 each  entry-mode bits.
- two_line  out  1  function-set N bit.
- shift_ofs  out  6  display shift offset, 0..39.
- overrun  out  1  sticky flag: strobe arrived while busy.
- addr_err  out  1  1-cycle pulse on an invalid DDRAM address.

Behaviour:
- Reset (rst_n low), asynchronous: all outputs 0 except entry_inc = 1 and two_line = 0; internal FSM goes to S_CLR.
- E sync/strobe: lcd_e passes through SYNC_STAGES flops. The falling edge of the synced E is the strobe. lcd_rs, lcd_rw and lcd_data are captured in the same cycle the edge is detected; the initiator holds them stable around the E fall.
- FSM states:
  - S_CLR: writes 0x20 to addresses 0..79, one per cycle; busy = 1; then loads the busy counter with BUSY_LONG and goes to S_BUSY. After reset the count is 80 cycles plus BUSY_LONG; the reset-time clear does not pulse wr_valid.
  - S_IDLE: busy = 0; waits for a strobe.
  - S_EXEC: one cycle; decodes and applies the captured access, then goes to S_BUSY (or S_CLR for clear display).
  - S_BUSY: counts down; returns to S_IDLE when the counter reaches 0.
- Latency: the captured effect (AC, registers, wr_valid) appears 1 cycle after the strobe is detected. busy rises in that same cycle.
- Instruction decode (rs = 0, rw = 0), highest set bit wins:
  - 1xxxxxxx: set DDRAM address. Valid ranges: two_line = 1 → 0x00-0x27 and 0x40-0x67; two_line = 0 → 0x00-0x4F. An invalid address pulses addr_err and leaves AC unchanged. Clears cgram_mode.
  - 01xxxxxx: set CGRAM address; sets internal cgram_mode. Data writes are then discarded (no wr_valid), but AC still steps.
  - 001DNFxx: two_line = N. D and F are ignored.
  - 0001SRxx: S = 0 moves AC (R = 1 increments, R = 0 decrements, using the wrap rules below). S = 1 changes shift_ofs by ±1 mod 40.
  - 00001DCB: display_on = D, cursor_on = C, blink_on = B.
  - 000001IS: entry_inc = I, entry_shift = S.
  - 0000001x: return home. AC = 0, shift_ofs = 0, busy time BUSY_LONG.
  - 00000001: clear display. Goes to S_CLR (same 80-cycle fill, no wr_valid), then AC = 0, entry_inc = 1, shift_ofs = 0, busy time BUSY_LONG.
  - 0x00: no-op, busy time BUSY_SHORT.
- Data write (rs = 1, rw = 0):
  - DDRAM[AC] = data; wr_valid pulses with wr_addr = AC and wr_char = data.
  - AC then steps by entry_inc.
  - If entry_shift = 1, shift_ofs also moves by ±1 mod 40.
- AC wrap rules:
  - two_line = 1: increment 0x27 → 0x40 and 0x67 → 0x00; decrement 0x00 → 0x67 and 0x40 → 0x27.
  - two_line = 0: increment 0x4F → 0x00; decrement 0x00 → 0x4F.
- Reads (rw = 1):
  - lcd_data_oe = synced E AND captured rw. The read value is latched on the synced E rising edge.
  - rs = 0: returns {busy, AC}; allowed while busy; no side effect.
  - rs = 1: returns DDRAM[AC]; AC steps on the strobe. Not allowed while busy.
- Strobe while busy: every access is dropped except a status read. overrun is set and stays set until reset.
- Reset mid-operation: abort immediately and restart S_CLR.
- DDRAM storage: addresses 0x40-0x67 map to physical locations 40-79. rd_data for an unmapped rd_addr returns 0x20.

Test Plan:
- Release reset, no strobes → busy = 1 for 80 + BUSY_LONG cycles, then 0; rd_data = 0x20 at addresses 0x00, 0x27, 0x40, 0x67; ac = 0; no wr_valid.
- Strobe 0x38, 0x08, 0x01, 0x06, 0x0C, each after busy clears → two_line = 1, display_on = 1, cursor_on = 0, entry_inc = 1, entry_shift = 0, ac = 0, overrun = 0.
- Strobe 0x80, then data "ODO:" → wr_valid pulses ×4 at wr_addr 0..3 with wr_char 0x4F, 0x44, 0x4F, 0x3A; ac = 4; rd_data at 0x00-0x03 matches.
- two_line = 1, strobe 0xA7 then data 0x41 → DDRAM[0x27] = 0x41, ac = 0x40. Strobe 0x04 then data 0x42 at 0x40 → ac = 0x27. Strobe 0xB0 → addr_err pulse, ac unchanged.
- Data write, then a second write strobe 100 cycles later → second write dropped, overrun = 1. A status read during busy returns lcd_data_out = {1, ac}.
- Assert rst_n low in the middle of a clear display fill → outputs return to reset values at once; after release the full 80 + BUSY_LONG busy period repeats and all locations read 0x20.
